// File: rtl/dpram_rr_arbiter.sv
// dpram_rr_arbiter: round-robin sharing of one two-port RAM among NUM_REQ requesters (write ack via DPRAM_ARB_WRITE_ACK_EN)
module dpram_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = 2,
  parameter int AWIDTH  = 11,
  parameter int DWIDTH  = 40
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_wren,
  input  logic [NUM_REQ*AWIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DWIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [AWIDTH-1:0]         ram_address_a,
  output logic [AWIDTH-1:0]         ram_address_b,
  output logic                      ram_wren_a,
  output logic                      ram_wren_b,
  output logic [DWIDTH-1:0]         ram_data_a,
  output logic [DWIDTH-1:0]         ram_data_b,
  input  logic [DWIDTH-1:0]         ram_out_a,
  input  logic [DWIDTH-1:0]         ram_out_b,
  output logic                      rsp_a_valid,
  output logic                      rsp_b_valid,
  output logic [IDW-1:0]            rsp_a_id,
  output logic [IDW-1:0]            rsp_b_id,
  output logic [DWIDTH-1:0]         rsp_a_data,
  output logic [DWIDTH-1:0]         rsp_b_data
);
  logic [AWIDTH-1:0] addr  [NUM_REQ];
  logic [DWIDTH-1:0] wdata [NUM_REQ];
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d, ia, ib, idx;
  logic ga, gb;
  logic a_vld_q, a_vld_d, a_wr_q, b_vld_q, b_vld_d, b_wr_q;
  logic [IDW-1:0] a_id_q, b_id_q;
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr[g]  = req_addr[g*AWIDTH +: AWIDTH];
    assign wdata[g] = req_wdata[g*DWIDTH +: DWIDTH];
  end
  // scan from the pointer: first valid wins A, next non-conflicting valid wins B
  always_comb begin
    ga  = 1'b0;
    gb  = 1'b0;
    ia  = '0;
    ib  = '0;
    idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = IDW'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (req_valid[idx] && resetn) begin
        if (!ga) begin
          ga = 1'b1;
          ia = idx;
        end else if (!gb && !(addr[idx] == addr[ia] && (req_wren[idx] || req_wren[ia]))) begin
          gb = 1'b1;
          ib = idx;
        end
      end
    end
  end
  assign rr_ptr_d = gb ? IDW'((int'(ib) + 1) % NUM_REQ) : ga ? IDW'((int'(ia) + 1) % NUM_REQ) : rr_ptr_q;
  assign req_ready = (ga ? NUM_REQ'(1) << ia : '0) | (gb ? NUM_REQ'(1) << ib : '0);
  assign ram_address_a = ga ? addr[ia] : '0;
  assign ram_address_b = gb ? addr[ib] : '0;
  assign ram_data_a    = ga ? wdata[ia] : '0;
  assign ram_data_b    = gb ? wdata[ib] : '0;
  assign ram_wren_a    = ga & req_wren[ia];
  assign ram_wren_b    = gb & req_wren[ib];
`ifdef DPRAM_ARB_WRITE_ACK_EN
  assign a_vld_d = ga;
  assign b_vld_d = gb;
`else
  assign a_vld_d = ga & ~req_wren[ia];
  assign b_vld_d = gb & ~req_wren[ib];
`endif
  // pointer and per-port in-flight records; reset drops pending responses
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rr_ptr_q <= '0;
      a_vld_q  <= 1'b0;
      a_wr_q   <= 1'b0;
      a_id_q   <= '0;
      b_vld_q  <= 1'b0;
      b_wr_q   <= 1'b0;
      b_id_q   <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      a_vld_q  <= a_vld_d;
      a_wr_q   <= ram_wren_a;
      a_id_q   <= ia;
      b_vld_q  <= b_vld_d;
      b_wr_q   <= ram_wren_b;
      b_id_q   <= ib;
    end
  end
  assign rsp_a_valid = a_vld_q;
  assign rsp_b_valid = b_vld_q;
  assign rsp_a_id    = a_vld_q ? a_id_q : '0;
  assign rsp_b_id    = b_vld_q ? b_id_q : '0;
  assign rsp_a_data  = (a_vld_q && !a_wr_q) ? ram_out_a : '0;
  assign rsp_b_data  = (b_vld_q && !b_wr_q) ? ram_out_b : '0;
endmodule
